// File: rtl/mem_bus_pkg.sv
// Shared encodings for the core's data-memory bus and the responder state type.
package mem_bus_pkg;

  localparam logic [1:0] HSIZE_B = 2'd0;
  localparam logic [1:0] HSIZE_H = 2'd1;
  localparam logic [1:0] HSIZE_W = 2'd2;
  localparam logic [1:0] HSIZE_D = 2'd3;

  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_ACTIVE = 1'b1;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_DATA,
    RSP_ERR1,
    RSP_ERR2
  } rsp_state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      HSIZE_B: size_mask = 8'h01;
      HSIZE_H: size_mask = 8'h03;
      HSIZE_W: size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_gen.sv
// Byte-lane strobe and natural-alignment check for a transfer of a given size.
module byte_lane_gen
  import mem_bus_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] addr_lo,
  output logic [7:0] strobe,
  output logic       misalign
);

  always_comb begin
    strobe = size_mask(size) << addr_lo;
    case (size)
      HSIZE_B: misalign = 1'b0;
      HSIZE_H: misalign = addr_lo[0];
      HSIZE_W: misalign = |addr_lo[1:0];
      default: misalign = |addr_lo;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: pipelined bus slave with wait states, byte-lane stores and two-cycle error.
//   state | meaning
//   IDLE  | no transfer in progress, ready for an address phase
//   WAIT  | inserted wait cycles before the data phase
//   DATA  | data phase completing, store commits / load data valid
//   ERR1  | first error cycle, bus stalled
//   ERR2  | second error cycle, error completes
module dmem_responder
  import mem_bus_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 512,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HSEL,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [63:0] RANGE_BYTES = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  WAIT_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  rsp_state_t    state, state_nxt;
  logic [AW-1:0] idx_q;
  logic          write_q;
  logic [7:0]    strb_q;
  logic [3:0]    wait_cnt;
  logic [63:0]   mem [DEPTH_WORDS];

  logic [63:0]   offset;
  logic          in_range;
  logic [7:0]    strb_new;
  logic          misalign;
  logic          addr_err;
  logic          accept;
  logic          commit;
  logic [AW-1:0] idx_new;
  logic [AW-1:0] rd_idx;
  logic [63:0]   rd_word;

  byte_lane_gen u_lane (
    .size     (HSIZE),
    .addr_lo  (HADDR[2:0]),
    .strobe   (strb_new),
    .misalign (misalign)
  );

  assign offset   = HADDR - BASE_ADDR;
  assign in_range = (HADDR >= BASE_ADDR) && (offset < RANGE_BYTES);
  assign addr_err = !in_range || misalign;
  assign idx_new  = offset[AW+2:3];

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    case (state)
      RSP_WAIT: HREADY = 1'b0;
      RSP_ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      RSP_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign accept = HSEL && (HTRANS == HTRANS_ACTIVE) && HREADY;
  assign commit = (state == RSP_DATA) && write_q;

  // IDLE, DATA and ERR2 all have HREADY high, so each may take a new address phase
  always_comb begin
    state_nxt = state;
    case (state)
      RSP_WAIT: if (wait_cnt == 4'd0) state_nxt = RSP_DATA;
      RSP_ERR1: state_nxt = RSP_ERR2;
      default: begin
        if (!accept)              state_nxt = RSP_IDLE;
        else if (addr_err)        state_nxt = RSP_ERR1;
        else if (WAIT_STATES > 0) state_nxt = RSP_WAIT;
        else                      state_nxt = RSP_DATA;
      end
    endcase
  end

  // Read source: a freshly accepted address when entering DATA directly, else the latched one
  assign rd_idx = (state == RSP_WAIT) ? idx_q : idx_new;

  always_comb begin
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int b = 0; b < 8; b++) begin
        if (strb_q[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= RSP_IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      wait_cnt <= '0;
      HRDATA   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q    <= idx_new;
        write_q  <= HWRITE && !addr_err;
        strb_q   <= strb_new;
        wait_cnt <= WAIT_RELOAD;
      end else if ((state == RSP_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      HRDATA <= (state_nxt == RSP_DATA) ? rd_word : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && commit) begin
      for (int b = 0; b < 8; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        HSEL1 = 1'b0;
  logic        HSEL0 = 1'b0;
  logic        HTRANS = 1'b0;
  logic [63:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HSIZE = 2'd0;
  logic [63:0] HWDATA = '0;
  logic [63:0] HRDATA1, HRDATA0;
  logic        HREADY1, HREADY0, HRESP1, HRESP0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(512), .WAIT_STATES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL1), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA1), .HREADY(HREADY1), .HRESP(HRESP1)
  );

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(512), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL0), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA0), .HREADY(HREADY0), .HRESP(HRESP0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete transfer on the one-wait-state instance; reports what the bus showed
  task automatic xfer1(input logic wr, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] rd, output int low,
                       output logic rf, output logic rl);
    HSEL1 = 1'b1; HTRANS = 1'b1; HADDR = a; HWRITE = wr; HSIZE = sz;
    tick();
    HSEL1 = 1'b0; HTRANS = 1'b0; HWDATA = wd;
    rf = HRESP1;
    low = 0;
    while (HREADY1 !== 1'b1 && low < 20) begin
      low++;
      tick();
    end
    rd = HRDATA1;
    rl = HRESP1;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    tick(); tick();
    n_assert++; if (HREADY1 !== 1'b1) begin n_fail++; $display("FAIL reset_hready1 got %b want 1", HREADY1); end
    n_assert++; if (HRESP1 !== 1'b0) begin n_fail++; $display("FAIL reset_hresp1 got %b want 0", HRESP1); end
    n_assert++; if (HRDATA1 !== 64'h0) begin n_fail++; $display("FAIL reset_hrdata1 got %h want 0", HRDATA1); end
    n_assert++; if (HREADY0 !== 1'b1 || HRESP0 !== 1'b0) begin n_fail++; $display("FAIL reset_dut0 got ready=%b resp=%b want 1/0", HREADY0, HRESP0); end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    logic [63:0] rd; int low; logic rf, rl;
    xfer1(1'b1, 2'd3, BASE + 64'h10, 64'h1122334455667788, rd, low, rf, rl);
    n_assert++; if (low != 1) begin n_fail++; $display("FAIL store_wait_cycles got %0d want 1", low); end
    n_assert++; if (rl !== 1'b0) begin n_fail++; $display("FAIL store_hresp got %b want 0", rl); end
    xfer1(1'b0, 2'd3, BASE + 64'h10, 64'h0, rd, low, rf, rl);
    n_assert++; if (low != 1) begin n_fail++; $display("FAIL load_wait_cycles got %0d want 1", low); end
    n_assert++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL load_data got %h want 1122334455667788", rd); end
    n_assert++; if (rl !== 1'b0) begin n_fail++; $display("FAIL load_hresp got %b want 0", rl); end
    n_assert++; if (HRDATA1 !== 64'h0) begin n_fail++; $display("FAIL idle_hrdata got %h want 0", HRDATA1); end
  endtask

  task automatic test_byte_store();
    logic [63:0] rd; int low; logic rf, rl;
    xfer1(1'b1, 2'd0, BASE + 64'h13, 64'hFFFFFFFFABFFFFFF, rd, low, rf, rl);
    n_assert++; if (low != 1 || rl !== 1'b0) begin n_fail++; $display("FAIL byte_store got low=%0d resp=%b want 1/0", low, rl); end
    xfer1(1'b0, 2'd3, BASE + 64'h10, 64'h0, rd, low, rf, rl);
    n_assert++; if (rd !== 64'h11223344AB667788) begin n_fail++; $display("FAIL byte_merge got %h want 11223344ab667788", rd); end
  endtask

  task automatic test_back_to_back();
    HSEL0 = 1'b1; HTRANS = 1'b1; HADDR = BASE + 64'h40; HWRITE = 1'b1; HSIZE = 2'd3;
    tick();
    n_assert++; if (HREADY0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a got %b want 1", HREADY0); end
    HADDR = BASE + 64'h42; HSIZE = 2'd1; HWDATA = 64'h0102030405060708;
    tick();
    n_assert++; if (HREADY0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_b got %b want 1", HREADY0); end
    n_assert++; if (HRDATA0 !== 64'h0102030405060708) begin n_fail++; $display("FAIL b2b_bypass_dword got %h want 0102030405060708", HRDATA0); end
    HADDR = BASE + 64'h40; HWRITE = 1'b0; HSIZE = 2'd3; HWDATA = 64'h99999999BEEF9999;
    tick();
    n_assert++; if (HREADY0 !== 1'b1 || HRESP0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_load got ready=%b resp=%b want 1/0", HREADY0, HRESP0); end
    n_assert++; if (HRDATA0 !== 64'h01020304BEEF0708) begin n_fail++; $display("FAIL b2b_bypass_half got %h want 01020304beef0708", HRDATA0); end
    HSEL0 = 1'b0; HTRANS = 1'b0; HWDATA = 64'h0;
    tick();
    n_assert++; if (HREADY0 !== 1'b1 || HRDATA0 !== 64'h0) begin n_fail++; $display("FAIL b2b_idle got ready=%b data=%h want 1/0", HREADY0, HRDATA0); end
    HSEL0 = 1'b1; HTRANS = 1'b1; HADDR = BASE + 64'h40; HWRITE = 1'b0;
    tick();
    n_assert++; if (HRDATA0 !== 64'h01020304BEEF0708) begin n_fail++; $display("FAIL b2b_readback got %h want 01020304beef0708", HRDATA0); end
    HSEL0 = 1'b0; HTRANS = 1'b0;
    tick();
  endtask

  task automatic test_error();
    logic [63:0] rd; int low; logic rf, rl;
    xfer1(1'b0, 2'd1, BASE + 64'h11, 64'h0, rd, low, rf, rl);
    n_assert++; if (low != 1 || rf !== 1'b1 || rl !== 1'b1) begin n_fail++; $display("FAIL err_misalign_half got low=%0d r1=%b r2=%b want 1/1/1", low, rf, rl); end
    xfer1(1'b1, 2'd3, BASE, 64'hA5A5A5A55A5A5A5A, rd, low, rf, rl);
    xfer1(1'b1, 2'd3, BASE + 64'h1000, 64'h0, rd, low, rf, rl);
    n_assert++; if (low != 1 || rf !== 1'b1 || rl !== 1'b1) begin n_fail++; $display("FAIL err_range_top got low=%0d r1=%b r2=%b want 1/1/1", low, rf, rl); end
    xfer1(1'b0, 2'd3, BASE, 64'h0, rd, low, rf, rl);
    n_assert++; if (rd !== 64'hA5A5A5A55A5A5A5A) begin n_fail++; $display("FAIL err_no_alias_write got %h want a5a5a5a55a5a5a5a", rd); end
    xfer1(1'b0, 2'd3, BASE - 64'h8, 64'h0, rd, low, rf, rl);
    n_assert++; if (rl !== 1'b1) begin n_fail++; $display("FAIL err_range_low got %b want 1", rl); end
    xfer1(1'b1, 2'd2, BASE + 64'h12, 64'h0, rd, low, rf, rl);
    n_assert++; if (rl !== 1'b1) begin n_fail++; $display("FAIL err_misalign_word got %b want 1", rl); end
    xfer1(1'b0, 2'd3, BASE + 64'h10, 64'h0, rd, low, rf, rl);
    n_assert++; if (rd !== 64'h11223344AB667788) begin n_fail++; $display("FAIL err_store_dropped got %h want 11223344ab667788", rd); end
    xfer1(1'b1, 2'd3, BASE + 64'hFF8, 64'hCAFEF00D12345678, rd, low, rf, rl);
    xfer1(1'b0, 2'd3, BASE + 64'hFF8, 64'h0, rd, low, rf, rl);
    n_assert++; if (rd !== 64'hCAFEF00D12345678 || rl !== 1'b0) begin n_fail++; $display("FAIL last_word got %h resp=%b want cafef00d12345678/0", rd, rl); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; int low; logic rf, rl;
    HSEL1 = 1'b1; HTRANS = 1'b1; HADDR = BASE + 64'h10; HWRITE = 1'b1; HSIZE = 2'd3;
    tick();
    n_assert++; if (HREADY1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_wait got %b want 0", HREADY1); end
    HSEL1 = 1'b0; HTRANS = 1'b0; HWDATA = 64'hDEADBEEFDEADBEEF; RESET = 1'b0;
    tick();
    n_assert++; if (HREADY1 !== 1'b1 || HRESP1 !== 1'b0 || HRDATA1 !== 64'h0) begin n_fail++; $display("FAIL rst_mid_outputs got ready=%b resp=%b data=%h want 1/0/0", HREADY1, HRESP1, HRDATA1); end
    RESET = 1'b1;
    tick();
    xfer1(1'b0, 2'd3, BASE + 64'h10, 64'h0, rd, low, rf, rl);
    n_assert++; if (rd !== 64'h11223344AB667788) begin n_fail++; $display("FAIL rst_mid_no_commit got %h want 11223344ab667788", rd); end
  endtask

  task automatic test_idle_cycles();
    logic [63:0] rd; int low; logic rf, rl;
    HSEL1 = 1'b1; HTRANS = 1'b0; HADDR = BASE + 64'h10; HWRITE = 1'b1; HSIZE = 2'd3; HWDATA = 64'h5555555555555555;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_assert++; if (HREADY1 !== 1'b1 || HRESP1 !== 1'b0 || HRDATA1 !== 64'h0) begin n_fail++; $display("FAIL idle_cycle%0d got ready=%b resp=%b data=%h want 1/0/0", i, HREADY1, HRESP1, HRDATA1); end
    end
    HSEL1 = 1'b0;
    xfer1(1'b0, 2'd3, BASE + 64'h10, 64'h0, rd, low, rf, rl);
    n_assert++; if (rd !== 64'h11223344AB667788) begin n_fail++; $display("FAIL idle_no_write got %h want 11223344ab667788", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_idle_cycles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
